// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: NOP, next-PC select encodings, fetch FSM
// states and opcode constants used by fetch and hazard detection.
package mips_pkg;

    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam logic [1:0] NPC_SEQ    = 2'd0;
    localparam logic [1:0] NPC_REG    = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_BRANCH = 2'd3;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_DRAIN,
        F_HOLD
    } fetch_state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    // Pseudo-direct jump: upper nibble of PC+4, 26-bit word index.
    function automatic logic [31:0] jump_target(input logic [3:0]  pc4_hi,
                                                input logic [25:0] instr_idx);
        return {pc4_hi, instr_idx, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry holding buffer for an instruction acknowledged while decode is
// stalled; used by fetch_unit when FETCH_BUF_EN is defined.
import mips_pkg::*;

module fetch_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] ir_i,
    input  logic [31:0] pc4_i,
    output logic        valid_o,
    output logic [31:0] ir_o,
    output logic [31:0] pc4_o
);

    logic        valid_q;
    logic [31:0] ir_q;
    logic [31:0] pc4_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ir_q    <= NOP;
            pc4_q   <= 32'h0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            ir_q    <= ir_i;
            pc4_q   <= pc4_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign ir_o    = ir_q;
    assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC, imem request/ack handshake, IF/ID register.
// Optional stall buffer enabled by defining FETCH_BUF_EN.
import mips_pkg::*;

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_en,
    input  logic        f2d_ir_en,
    input  logic        flush,
    input  logic [1:0]  next_pc_sel,
    input  logic [31:0] rs_data,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] f2d_ir,
    output logic [31:0] f2d_pc4,
    output logic        f2d_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  stale_q, stale_d;
    logic [31:0]  ir_q, ir_d;
    logic [31:0]  pc4_q, pc4_d;
    logic         valid_q, valid_d;

    logic         redirect;
    logic         stalled;
    logic [31:0]  pc_plus4;
    logic [31:0]  target;
    logic         new_valid;
    logic [31:0]  new_ir;
    logic [31:0]  new_pc4;

`ifdef FETCH_BUF_EN
    logic         buf_load;
    logic         buf_clear;
    logic         buf_valid;
    logic [31:0]  buf_ir;
    logic [31:0]  buf_pc4;

    fetch_buf u_fetch_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .ir_i    (imem_rdata),
        .pc4_i   (pc_plus4),
        .valid_o (buf_valid),
        .ir_o    (buf_ir),
        .pc4_o   (buf_pc4)
    );
`endif

    assign redirect = (next_pc_sel != NPC_SEQ);
    // A fetch is only consumed when both PC and F2D may move and nothing flushes.
    assign stalled  = flush || !f2d_ir_en || !pc_en;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        target = pc_plus4;
        case (next_pc_sel)
            NPC_REG:    target = rs_data;
            NPC_JUMP:   target = jump_target(pc4_q[31:28], ir_q[25:0]);
            NPC_BRANCH: target = branch_target;
            default:    target = pc_plus4;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        stale_d   = stale_q;
        new_valid = 1'b0;
        new_ir    = imem_rdata;
        new_pc4   = pc_plus4;
`ifdef FETCH_BUF_EN
        buf_load  = 1'b0;
        buf_clear = 1'b0;
`endif
        case (state_q)
            F_IDLE: begin
                state_d = F_REQ;
            end
            F_REQ: begin
                if (redirect) begin
                    pc_d = target;
                    if (!imem_ack) begin
                        stale_d = pc_q;
                        state_d = F_DRAIN;
                    end
                end else if (imem_ack) begin
                    if (!stalled) begin
                        new_valid = 1'b1;
                        pc_d      = pc_plus4;
                    end else begin
                        state_d = F_HOLD;
`ifdef FETCH_BUF_EN
                        buf_load = 1'b1;
`endif
                    end
                end
            end
            F_DRAIN: begin
                // The stale address stays on the bus; only its ack is thrown away.
                if (redirect) begin
                    pc_d = target;
                end
                if (imem_ack) begin
                    state_d = F_REQ;
                end
            end
            F_HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = F_REQ;
`ifdef FETCH_BUF_EN
                    buf_clear = 1'b1;
`endif
                end else if (!stalled) begin
                    state_d = F_REQ;
`ifdef FETCH_BUF_EN
                    if (buf_valid) begin
                        new_valid = 1'b1;
                        new_ir    = buf_ir;
                        new_pc4   = buf_pc4;
                        pc_d      = pc_plus4;
                        buf_clear = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = F_IDLE;
            end
        endcase
    end

    // An enabled F2D with nothing new becomes a bubble so decode never
    // sees the same instruction twice.
    always_comb begin
        ir_d    = ir_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush || (f2d_ir_en && !new_valid)) begin
            ir_d    = NOP;
            valid_d = 1'b0;
        end else if (new_valid) begin
            ir_d    = new_ir;
            pc4_d   = new_pc4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= F_IDLE;
            pc_q    <= RESET_PC;
            stale_q <= RESET_PC;
            ir_q    <= NOP;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stale_q <= stale_d;
            ir_q    <= ir_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req  = (state_q == F_REQ) || (state_q == F_DRAIN);
    assign imem_addr = (state_q == F_DRAIN) ? stale_q : pc_q;
    assign f2d_ir    = ir_q;
    assign f2d_pc4   = pc4_q;
    assign f2d_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic
// against a program-order scoreboard and a variable-latency memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_en = 1'b1;
    logic        f2d_ir_en = 1'b1;
    logic        flush = 1'b0;
    logic [1:0]  next_pc_sel = 2'd0;
    logic [31:0] rs_data = 32'h0;
    logic [31:0] branch_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] f2d_ir;
    logic [31:0] f2d_pc4;
    logic        f2d_valid;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_en         (pc_en),
        .f2d_ir_en     (f2d_ir_en),
        .flush         (flush),
        .next_pc_sel   (next_pc_sel),
        .rs_data       (rs_data),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .f2d_ir        (f2d_ir),
        .f2d_pc4       (f2d_pc4),
        .f2d_valid     (f2d_valid)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // memory model state
    logic        pending = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          wait_cnt = 0;
    int          cur_lat = 0;
    int          lat = 0;
    logic        lat_rand = 1'b0;
    logic [31:0] watch_addr = 32'hFFFF_FFFF;
    int          watch_cnt = 0;

    // architectural model: next PC to enter decode and current IF/ID contents
    logic [31:0] exp_pc = 32'h100;
    logic [31:0] model_ir = 32'h0;
    logic [31:0] model_pc4 = 32'h0;
    logic        model_valid = 1'b0;
    int          n_deliv = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h2001_0001;
            32'h0000_0104: return 32'h2002_0002;
            32'h1000_0000: return 32'h0800_0040;
            default:       return (a * 32'h9E37_79B1) ^ 32'h2000_0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mem_drive();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (imem_req) begin
            if (pending) begin
                chk("addr_stable", imem_addr, pend_addr);
            end else begin
                pending   = 1'b1;
                pend_addr = imem_addr;
                wait_cnt  = 0;
                cur_lat   = lat_rand ? $urandom_range(0, 3) : lat;
            end
            if (wait_cnt >= cur_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(pend_addr);
            end else begin
                wait_cnt++;
            end
        end else if (pending) begin
            chk("req_held", {31'h0, imem_req}, 32'h1);
        end
    endtask

    task automatic step(input logic pe, input logic ire, input logic fl,
                        input logic [1:0] sel, input logic [31:0] rs, input logic [31:0] bt);
        logic [31:0] tgt;
        @(negedge clk);
        pc_en = pe; f2d_ir_en = ire; flush = fl;
        next_pc_sel = sel; rs_data = rs; branch_target = bt;
        case (sel)
            2'd1:    tgt = rs;
            2'd2:    tgt = {model_pc4[31:28], model_ir[25:0], 2'b00};
            2'd3:    tgt = bt;
            default: tgt = exp_pc;
        endcase
        mem_drive();
        @(posedge clk);
        #1;
        if (imem_ack) begin
            pending = 1'b0;
            if (pend_addr == watch_addr) watch_cnt++;
        end
        if (fl) begin
            chk("flush_ir", f2d_ir, 32'h0);
            chk("flush_valid", {31'h0, f2d_valid}, 32'h0);
            chk("flush_pc4", f2d_pc4, model_pc4);
            model_ir = 32'h0; model_valid = 1'b0;
        end else if (!ire) begin
            chk("hold_ir", f2d_ir, model_ir);
            chk("hold_pc4", f2d_pc4, model_pc4);
            chk("hold_valid", {31'h0, f2d_valid}, {31'h0, model_valid});
        end else if (f2d_valid) begin
            chk("deliver_ir", f2d_ir, mem_word(exp_pc));
            chk("deliver_pc4", f2d_pc4, exp_pc + 32'd4);
            model_ir = mem_word(exp_pc); model_pc4 = exp_pc + 32'd4; model_valid = 1'b1;
            exp_pc = exp_pc + 32'd4;
            n_deliv++;
        end else begin
            chk("bubble_ir", f2d_ir, 32'h0);
            chk("bubble_pc4", f2d_pc4, model_pc4);
            model_ir = 32'h0; model_valid = 1'b0;
        end
        if (sel != 2'd0) exp_pc = tgt;
    endtask

    task automatic run();
        step(1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0);
    endtask

    task automatic redirect(input logic [1:0] sel, input logic [31:0] t);
        step(1'b1, 1'b1, 1'b1, sel, t, t);
    endtask

    task automatic wait_delivery(input int bound);
        int start;
        start = n_deliv;
        for (int i = 0; i < bound && n_deliv == start; i++) run();
        chk("deliver_timeout", {31'h0, n_deliv != start}, 32'h1);
    endtask

    task automatic drain_pending(input int bound);
        for (int i = 0; i < bound && pending; i++) run();
        chk("drain_ack", {31'h0, pending}, 32'h0);
    endtask

    initial begin
        int r;
        int start;
        logic [31:0] t;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h100);
        chk("rst_ir", f2d_ir, 32'h0);
        chk("rst_pc4", f2d_pc4, 32'h0);
        chk("rst_valid", {31'h0, f2d_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_req", {31'h0, imem_req}, 32'h0);
        @(posedge clk);
        #1;
        chk("first_req", {31'h0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h100);

        // zero-wait streaming
        lat = 0;
        run();
        chk("t1_ir0", f2d_ir, 32'h2001_0001);
        chk("t1_pc4_0", f2d_pc4, 32'h104);
        chk("t1_valid0", {31'h0, f2d_valid}, 32'h1);
        run();
        chk("t1_ir1", f2d_ir, 32'h2002_0002);
        chk("t1_pc4_1", f2d_pc4, 32'h108);
        chk("t1_valid1", {31'h0, f2d_valid}, 32'h1);

        // stall at 0x108 with an ack landing during the stall
        watch_addr = 32'h108;
        watch_cnt  = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
            chk("stall_addr", imem_addr, 32'h108);
            chk("stall_ir", f2d_ir, 32'h2002_0002);
            chk("stall_pc4", f2d_pc4, 32'h108);
        end
        for (int i = 0; i < 4; i++) run();
`ifdef FETCH_BUF_EN
        chk("stall_fetches", watch_cnt, 32'd1);
`else
        chk("stall_fetches", watch_cnt, 32'd2);
`endif
        chk("stall_exp_pc", {31'h0, exp_pc > 32'h108}, 32'h1);

        // taken branch while a 3-cycle fetch is outstanding
        lat = 3;
        run();
        redirect(2'd3, 32'h200);
        chk("br_ir", f2d_ir, 32'h0);
        chk("br_valid", {31'h0, f2d_valid}, 32'h0);
        chk("br_drain_req", {31'h0, imem_req}, 32'h1);
        drain_pending(8);
        chk("br_next_req", {31'h0, imem_req}, 32'h1);
        chk("br_next_addr", imem_addr, 32'h200);
        wait_delivery(10);

        // two redirects while draining: only the last target is fetched
        run();
        redirect(2'd1, 32'h400);
        redirect(2'd3, 32'h440);
        drain_pending(8);
        chk("dbl_next_addr", imem_addr, 32'h440);
        wait_delivery(10);

        // jump computed from the IF/ID contents
        lat = 0;
        redirect(2'd3, 32'h1000_0000);
        chk("redir0_addr", imem_addr, 32'h1000_0000);
        run();
        chk("j_ir", f2d_ir, 32'h0800_0040);
        chk("j_pc4", f2d_pc4, 32'h1000_0004);
        chk("j_valid", {31'h0, f2d_valid}, 32'h1);
        redirect(2'd2, 32'h0);
        chk("j_req", {31'h0, imem_req}, 32'h1);
        chk("j_addr", imem_addr, 32'h1000_0100);
        wait_delivery(4);

        // reset while draining
        lat = 3;
        run();
        redirect(2'd3, 32'h300);
        chk("drain_addr", imem_addr, pend_addr);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
        chk("mid_rst_addr", imem_addr, 32'h100);
        chk("mid_rst_ir", f2d_ir, 32'h0);
        chk("mid_rst_pc4", f2d_pc4, 32'h0);
        chk("mid_rst_valid", {31'h0, f2d_valid}, 32'h0);
        pending = 1'b0; exp_pc = 32'h100;
        model_ir = 32'h0; model_pc4 = 32'h0; model_valid = 1'b0;
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_0BAD;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("late_ack_valid", {31'h0, f2d_valid}, 32'h0);
        chk("late_ack_ir", f2d_ir, 32'h0);
        chk("restart_req", {31'h0, imem_req}, 32'h1);
        chk("restart_addr", imem_addr, 32'h100);
        lat = 0;
        wait_delivery(4);
        chk("restart_pc4", f2d_pc4, 32'h104);

        // random traffic, including targets near the top of the address space
        lat_rand = 1'b1;
        start = n_deliv;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                if ($urandom_range(0, 3) == 0)
                    t = 32'hFFFF_FFF0 + {28'h0, 2'($urandom_range(0, 3)), 2'b00};
                else
                    t = {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
                redirect(($urandom_range(0, 1) == 0) ? 2'd1 : 2'd3, t);
            end else if (r < 30) begin
                step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
            end else begin
                run();
            end
        end
        chk("rand_progress", {31'h0, (n_deliv - start) > 40}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
